cpu_sequencer: RTL and testbench

//   Parametrised CPU control sequencer; next generation of the 4-state core init FSM.

---
 rtl/cpu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// CPU control sequencer: start gate, register-load sweep, fetch/decode/execute/writeback
// handshakes, fetch timeout, halt/resume and sticky fault. Define CPU_SEQ_PERF_CNT_EN for counters.
module cpu_sequencer #(
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned REG_IDX_W     = 3,
    parameter int unsigned PC_W          = 16,
    parameter int unsigned RESET_PC      = 0,
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 fetch_ack,
    input  logic                 exec_done,
    input  logic                 halt_req,
    output logic [2:0]           state,
    output logic                 reg_load_en,
    output logic [REG_IDX_W-1:0] reg_load_idx,
    output logic                 fetch_req,
    output logic [PC_W-1:0]      pc,
    output logic                 exec_en,
    output logic                 wb_en,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt
`endif
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StLoadRegs  = 3'd1,
        StFetch     = 3'd2,
        StDecode    = 3'd3,
        StExecute   = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6,
        StFault     = 3'd7
    } state_e;

    // Counter only needs to reach FETCH_TIMEOUT-1; the last miss goes straight to FAULT.
    localparam int unsigned ToW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [ToW-1:0]       tcnt_q, tcnt_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 halt_pend_q, halt_pend_d;

    logic busy_w;
    logic last_reg;
    logic timeout_hit;

    assign busy_w      = (state_q == StLoadRegs) || (state_q == StFetch) ||
                         (state_q == StDecode) || (state_q == StExecute) ||
                         (state_q == StWriteback);
    assign last_reg    = (32'(idx_q) == NUM_REGS - 1);
    assign timeout_hit = (FETCH_TIMEOUT != 0) && (32'(tcnt_q) == FETCH_TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        pc_d        = pc_q;
        halt_pend_d = halt_pend_q;

        if (busy_w && halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            StInit: begin
                if (start) begin
                    state_d = StLoadRegs;
                end
            end
            StLoadRegs: begin
                if (last_reg) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + REG_IDX_W'(1);
                end
            end
            StFetch: begin
                // An ack on the limit cycle takes priority over the timeout.
                if (fetch_ack) begin
                    state_d = StDecode;
                    tcnt_d  = '0;
                end else if (timeout_hit) begin
                    state_d = StFault;
                    tcnt_d  = '0;
                end else if (FETCH_TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + ToW'(1);
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                if (exec_done) begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                pc_d = pc_q + PC_W'(1);
                // A request arriving in writeback itself still stops at this boundary.
                if (halt_pend_q || halt_req) begin
                    state_d     = StHalt;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StInit;
            idx_q       <= '0;
            tcnt_q      <= '0;
            pc_q        <= PC_W'(RESET_PC);
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            pc_q        <= pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign state        = state_q;
    assign reg_load_en  = (state_q == StLoadRegs);
    assign reg_load_idx = idx_q;
    assign fetch_req    = (state_q == StFetch);
    assign pc           = pc_q;
    assign exec_en      = (state_q == StExecute);
    assign wb_en        = (state_q == StWriteback);
    assign busy         = busy_w;
    assign halted       = (state_q == StHalt);
    assign fault        = (state_q == StFault);

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (busy_w) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (state_q == StWriteback) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of the sequencer.
module tb_cpu_sequencer;

    localparam int unsigned NR = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned PW = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          fetch_ack;
    logic          exec_done;
    logic          halt_req;
    logic [2:0]    state;
    logic          reg_load_en;
    logic [IW-1:0] reg_load_idx;
    logic          fetch_req;
    logic [PW-1:0] pc;
    logic          exec_en;
    logic          wb_en;
    logic          busy;
    logic          halted;
    logic          fault;
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] instr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .NUM_REGS     (NR),
        .REG_IDX_W    (IW),
        .PC_W         (PW),
        .RESET_PC     (0),
        .FETCH_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .fetch_ack   (fetch_ack),
        .exec_done   (exec_done),
        .halt_req    (halt_req),
        .state       (state),
        .reg_load_en (reg_load_en),
        .reg_load_idx(reg_load_idx),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .exec_en     (exec_en),
        .wb_en       (wb_en),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
`ifdef CPU_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase name, position in the load sweep, fetch wait count, pc.
    int          m_phase  = 0;
    int          m_idx    = 0;
    int          m_wait   = 0;
    int          m_pc     = 0;
    bit          m_hold   = 0;
    logic [31:0] m_cyc    = 0;
    logic [31:0] m_ins    = 0;
    bit          chk_en   = 0;

    always @(posedge clk) begin
        int p;
        p = m_phase;
        if (!reset_n) begin
            m_phase = 0; m_idx = 0; m_wait = 0; m_pc = 0; m_hold = 0;
            m_cyc = 0; m_ins = 0; chk_en = 1;
        end else begin
            if (p >= 1 && p <= 5) begin
                m_cyc = m_cyc + 1;
                if (halt_req) m_hold = 1;
            end
            if (p == 5) m_ins = m_ins + 1;
            if (p == 0 && start) m_phase = 1;
            if (p == 1) begin
                m_idx = m_idx + 1;
                if (m_idx == NR) begin m_idx = 0; m_phase = 2; end
            end
            if (p == 2) begin
                m_wait = m_wait + 1;
                if (fetch_ack) begin m_wait = 0; m_phase = 3; end
                else if (m_wait >= TO) begin m_wait = 0; m_phase = 7; end
            end
            if (p == 3) m_phase = 4;
            if (p == 4 && exec_done) m_phase = 5;
            if (p == 5) begin
                m_pc = (m_pc + 1) % (1 << PW);
                m_phase = m_hold ? 6 : 2;
                m_hold = 0;
            end
            if (p == 6 && start) m_phase = 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", 32'(state), 32'(m_phase));
            check("m_load_en", 32'(reg_load_en), 32'(m_phase == 1));
            check("m_load_idx", 32'(reg_load_idx), 32'(m_idx));
            check("m_fetch_req", 32'(fetch_req), 32'(m_phase == 2));
            check("m_pc", 32'(pc), 32'(m_pc));
            check("m_exec_en", 32'(exec_en), 32'(m_phase == 4));
            check("m_wb_en", 32'(wb_en), 32'(m_phase == 5));
            check("m_busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 5));
            check("m_halted", 32'(halted), 32'(m_phase == 6));
            check("m_fault", 32'(fault), 32'(m_phase == 7));
`ifdef CPU_SEQ_PERF_CNT_EN
            check("m_cycle_cnt", cycle_cnt, m_cyc);
            check("m_instr_cnt", instr_cnt, m_ins);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait instruction from FETCH back to FETCH: 4 cycles.
    task automatic run_instr();
        fetch_ack = 1; tick(); fetch_ack = 0;
        tick();
        exec_done = 1; tick(); exec_done = 0;
        tick();
    endtask

    initial begin
        bit slow;
        reset_n = 0; start = 0; fetch_ack = 0; exec_done = 0; halt_req = 0;
        tick(); tick();
        check("rst_state", 32'(state), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1;

        // Load sweep
        start = 1; tick(); start = 0;
        for (int i = 0; i < 8; i++) begin
            check("load_idx", 32'(reg_load_idx), 32'(i));
            check("load_en", 32'(reg_load_en), 1);
            tick();
        end
        check("load_done_state", 32'(state), 2);
        check("load_done_en", 32'(reg_load_en), 0);

        // Ack in third fetch cycle, done in second execute cycle
        tick(); tick();
        fetch_ack = 1; tick(); fetch_ack = 0;
        check("decode_state", 32'(state), 3);
        tick();
        check("exec_en", 32'(exec_en), 1);
        tick();
        exec_done = 1; tick(); exec_done = 0;
        check("wb_en", 32'(wb_en), 1);
        check("wb_pc", 32'(pc), 0);
        tick();
        check("post_wb_state", 32'(state), 2);
        check("post_wb_pc", 32'(pc), 1);
        check("post_wb_en", 32'(wb_en), 0);

        // Ack on the 15th fetch cycle wins over timeout
        repeat (14) tick();
        check("to_edge_state", 32'(state), 2);
        fetch_ack = 1; tick(); fetch_ack = 0;
        check("to_ack_state", 32'(state), 3);
        check("to_ack_fault", 32'(fault), 0);
        tick();
        exec_done = 1; tick(); exec_done = 0;
        tick();
        check("pc_2", 32'(pc), 2);

        // No ack: fault after 15 fetch cycles, sticky against start
        repeat (14) tick();
        check("to_pre_state", 32'(state), 2);
        tick();
        check("to_state", 32'(state), 7);
        check("to_fault", 32'(fault), 1);
        check("to_fetch_req", 32'(fetch_req), 0);
        start = 1; tick(); start = 0;
        check("fault_sticky", 32'(state), 7);
        reset_n = 0; tick(); reset_n = 1;
        check("fault_rst_state", 32'(state), 0);

        // Halt at boundary, resume without reload
        start = 1; tick(); start = 0;
        repeat (8) tick();
        fetch_ack = 1; tick(); fetch_ack = 0;
        tick();
        halt_req = 1; tick(); halt_req = 0;
        exec_done = 1; tick(); exec_done = 0;
        check("halt_wb_state", 32'(state), 5);
        tick();
        check("halt_state", 32'(state), 6);
        check("halt_flag", 32'(halted), 1);
        check("halt_pc", 32'(pc), 1);
        repeat (3) tick();
        check("halt_hold", 32'(state), 6);
        start = 1; tick(); start = 0;
        check("resume_state", 32'(state), 2);
        check("resume_pc", 32'(pc), 1);
        check("resume_no_load", 32'(reg_load_en), 0);

        // PC wrap at 4 bits, then reset mid-execute
        repeat (14) run_instr();
        check("pc_15", 32'(pc), 15);
        run_instr();
        check("pc_wrap", 32'(pc), 0);
        fetch_ack = 1; tick(); fetch_ack = 0;
        tick();
        check("mid_exec_state", 32'(state), 4);
        reset_n = 0; tick(); reset_n = 1;
        check("rst_exec_state", 32'(state), 0);
        check("rst_exec_pc", 32'(pc), 0);
        check("rst_exec_outs", {22'd0, reg_load_en, fetch_req, exec_en, wb_en, busy, halted,
                                fault, 3'd0}, 0);

        // Three 4-cycle instructions after an 8-cycle load
        start = 1; tick(); start = 0;
        repeat (8) tick();
        repeat (3) run_instr();
        check("three_pc", 32'(pc), 3);
`ifdef CPU_SEQ_PERF_CNT_EN
        check("perf_instr", instr_cnt, 3);
        check("perf_cycle", cycle_cnt, 20);
`endif

        // Randomized traffic, model-checked every cycle
        slow = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) slow = ($urandom_range(0, 2) == 0);
            reset_n   = ($urandom_range(0, 149) != 0);
            start     = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 19) == 0);
            exec_done = ($urandom_range(0, 1) == 0);
            fetch_ack = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            tick();
        end
        reset_n = 1; start = 0; halt_req = 0; exec_done = 0; fetch_ack = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
